// File: rtl/tmc_spi_board_emu.sv
`default_nettype none
`timescale 1ns / 1ps
// =============================================================================
// Module   : tmc_spi_board_emu
// Brief    : SPI mode-0 responder emulating a temperature readout board with
//            NUM_DEV chip-select-addressed devices of 3 R/W regs + status.
// Revision : 1.0 - initial release
// =============================================================================
module tmc_spi_board_emu #(
    parameter int   NUM_DEV  = 3,
    parameter int   DATA_W   = 24,
    parameter logic LIVE_VAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               mosi,
    input  logic [NUM_DEV-1:0] csn,
    output logic               miso,
    output logic               miso_oe,
    output logic               live,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int             DEV_W      = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int             CNT_W      = 6;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(8 + DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    // Input synchronizers; the third stage on sclk/csn gives edge detection.
    logic               sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic               mosi_s1_q, mosi_s2_q;
    logic [NUM_DEV-1:0] csn_s1_q, csn_s2_q, csn_s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            csn_s1_q  <= '0;
            csn_s2_q  <= '0;
            csn_s3_q  <= '0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            csn_s1_q  <= csn;
            csn_s2_q  <= csn_s1_q;
            csn_s3_q  <= csn_s2_q;
        end
    end

    state_t                                 state_q, state_d;
    logic [DEV_W-1:0]                       dev_q, dev_d;
    logic [CNT_W-1:0]                       bit_cnt_q, bit_cnt_d;
    logic                                   rd_q, rd_d;
    logic [1:0]                             addr_q, addr_d;
    logic [DATA_W-1:0]                      tx_q, tx_d;
    logic [DATA_W-2:0]                      rx_q, rx_d;
    logic                                   miso_q, miso_d;
    logic                                   oe_q, oe_d;
    logic                                   done_q, done_d;
    logic                                   err_q, err_d;
    logic                                   live_q;
    logic [NUM_DEV-1:0][2:0][DATA_W-1:0]    regs_q, regs_d;
    logic [NUM_DEV-1:0][7:0]                fcnt_q, fcnt_d;
    logic [NUM_DEV-1:0][7:0]                ecnt_q, ecnt_d;

    logic               w_rise, w_fall;
    logic [NUM_DEV-1:0] w_fell, w_chg;
    logic [7:0]         w_nlow;
    logic [DEV_W-1:0]   w_idx;
    logic [1:0]         w_addr;
    logic [DATA_W-1:0]  w_snap;

    assign w_rise = sclk_s2_q & ~sclk_s3_q;
    assign w_fall = ~sclk_s2_q & sclk_s3_q;
    assign w_fell = csn_s3_q & ~csn_s2_q;
    assign w_chg  = csn_s3_q ^ csn_s2_q;
    assign w_addr = {addr_q[0], mosi_s2_q};

    always_comb begin
        w_nlow = 8'd0;
        w_idx  = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (!csn_s2_q[i]) begin
                w_nlow = w_nlow + 8'd1;
                w_idx  = DEV_W'(i);
            end
        end
    end

    always_comb begin
        if (w_addr == 2'd3) begin
            w_snap = {{(DATA_W-16){1'b0}}, ecnt_q[dev_q], fcnt_q[dev_q]};
        end else begin
            w_snap = regs_q[dev_q][w_addr];
        end
    end

    always_comb begin
        state_d   = state_q;
        dev_d     = dev_q;
        bit_cnt_d = bit_cnt_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        regs_d    = regs_q;
        fcnt_d    = fcnt_q;
        ecnt_d    = ecnt_q;

        // While a device is selected, any csn movement (own rise or another
        // device toggling) ends the frame as an error.
        if ((state_q == S_CMD || state_q == S_DATA) && (|w_chg)) begin
            ecnt_d[dev_q] = ecnt_q[dev_q] + 8'd1;
            err_d         = 1'b1;
            miso_d        = 1'b0;
            oe_d          = 1'b0;
            state_d       = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|w_fell) begin
                        if (w_nlow == 8'd1) begin
                            dev_d     = w_idx;
                            bit_cnt_d = '0;
                            oe_d      = 1'b1;
                            miso_d    = 1'b0;
                            state_d   = S_CMD;
                        end else if (w_nlow > 8'd1) begin
                            oe_d  = 1'b0;
                            err_d = 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        addr_d    = w_addr;
                        if (bit_cnt_q == '0) begin
                            rd_d = mosi_s2_q;
                        end
                        if (bit_cnt_q == CMD_LAST) begin
                            tx_d    = w_snap;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        rx_d      = {rx_q[DATA_W-3:0], mosi_s2_q};
                        if (bit_cnt_q == FRAME_LAST) begin
                            if (!rd_q && addr_q != 2'd3) begin
                                regs_d[dev_q][addr_q] = {rx_q, mosi_s2_q};
                            end
                            fcnt_d[dev_q] = fcnt_q[dev_q] + 8'd1;
                            done_d        = 1'b1;
                            miso_d        = 1'b0;
                            state_d       = S_TAIL;
                        end
                    end else if (w_fall && rd_q) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
                S_TAIL: begin
                    miso_d = 1'b0;
                    if (csn_s2_q[dev_q] && !csn_s3_q[dev_q]) begin
                        oe_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dev_q     <= '0;
            bit_cnt_q <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            live_q    <= LIVE_VAL;
            regs_q    <= '0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            dev_q     <= dev_d;
            bit_cnt_q <= bit_cnt_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
            fcnt_q    <= fcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = oe_q;
    assign live       = live_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tmc_spi_board_emu.sv
`default_nettype none
`timescale 1ns / 1ps
// =============================================================================
// Module   : tb_tmc_spi_board_emu
// Brief    : Directed self-checking bench acting as the SPI master.
// Revision : 1.0 - initial release
// =============================================================================
module tb_tmc_spi_board_emu;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic [2:0] csn;
    logic       miso, miso_oe, live, frame_done, frame_err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_done = 0;
    int n_err = 0;
    int done0, err0;
    logic [31:0] rx;
    logic [23:0] rd;

    tmc_spi_board_emu #(
        .NUM_DEV  (3),
        .DATA_W   (24),
        .LIVE_VAL (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .csn        (csn),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .live       (live),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Half an SCLK period: 8 clk, all stimulus changes on the falling clk edge.
    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_low(input int dev);
        logic [2:0] one;
        one = 3'b001;
        csn = ~(one << dev);
        half();
    endtask

    task automatic cs_high();
        half();
        csn = 3'b111;
        half();
        half();
    endtask

    task automatic xfer(input logic [31:0] frame, input int nbits, output logic [31:0] r);
        r = '0;
        for (int b = 0; b < nbits; b++) begin
            mosi = frame[31-b];
            half();
            r = {r[30:0], miso};
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int dev, input logic [7:0] cmd, input logic [23:0] data,
                         output logic [23:0] rdata);
        logic [31:0] r;
        cs_low(dev);
        xfer({cmd, data}, 32, r);
        cs_high();
        rdata = r[23:0];
    endtask

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        csn  = 3'b111;
        repeat (5) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_live", {31'd0, live}, 32'd1);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Read dev0 addr0 straight after reset
        chk("oe_before", {31'd0, miso_oe}, 32'd0);
        done0 = n_done;
        cs_low(0);
        xfer(32'h8000_0000, 32, rx);
        chk("oe_during", {31'd0, miso_oe}, 32'd1);
        cs_high();
        chk("oe_after", {31'd0, miso_oe}, 32'd0);
        chk("rd_d0a0", rx, 32'd0);
        chk("done_d0a0", n_done - done0, 32'd1);

        // Write then read back dev1 addr2, then status
        done0 = n_done;
        frame(1, 8'h02, 24'hA5C33C, rd);
        frame(1, 8'h82, 24'h000000, rd);
        chk("rd_d1a2", {8'd0, rd}, 32'h00A5C33C);
        chk("done_wr_rd", n_done - done0, 32'd2);
        frame(1, 8'h83, 24'h000000, rd);
        chk("stat_d1", {8'd0, rd}, 32'h00000002);

        // Abort a dev2 write after 20 bits
        err0 = n_err;
        done0 = n_done;
        cs_low(2);
        xfer({8'h01, 24'hFFFFFF}, 20, rx);
        cs_high();
        chk("abort_err", n_err - err0, 32'd1);
        chk("abort_done", n_done - done0, 32'd0);
        chk("abort_oe", {31'd0, miso_oe}, 32'd0);
        frame(2, 8'h83, 24'h000000, rd);
        chk("stat_d2", {8'd0, rd}, 32'h00000100);
        frame(2, 8'h81, 24'h000000, rd);
        chk("rd_d2a1", {8'd0, rd}, 32'd0);

        // Two devices selected at once
        err0 = n_err;
        done0 = n_done;
        csn = 3'b100;
        half();
        chk("multi_oe", {31'd0, miso_oe}, 32'd0);
        csn = 3'b111;
        half();
        chk("multi_err", n_err - err0, 32'd1);
        chk("multi_done", n_done - done0, 32'd0);
        frame(0, 8'h83, 24'h000000, rd);
        chk("stat_d0", {8'd0, rd}, 32'h00000001);
        frame(1, 8'h83, 24'h000000, rd);
        chk("stat_d1b", {8'd0, rd}, 32'h00000003);
        frame(2, 8'h83, 24'h000000, rd);
        chk("stat_d2b", {8'd0, rd}, 32'h00000102);

        // Write to the read-only status address (ignored bits in cmd[6:2])
        done0 = n_done;
        frame(0, 8'h7F, 24'h123456, rd);
        chk("wr_a3_done", n_done - done0, 32'd1);
        frame(0, 8'hFF, 24'h000000, rd);
        chk("stat_d0b", {8'd0, rd}, 32'h00000003);

        // Reset in the middle of a frame, csn held low across reset release
        cs_low(1);
        xfer({8'h00, 24'h777777}, 14, rx);
        mosi = 1'b1;
        half();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("mid_rst_miso", {31'd0, miso}, 32'd0);
        chk("mid_rst_live", {31'd0, live}, 32'd1);
        rst = 1'b0;
        err0 = n_err;
        done0 = n_done;
        xfer({8'h80, 24'h000000}, 4, rx);
        chk("stale_cs_oe", {31'd0, miso_oe}, 32'd0);
        cs_high();
        chk("stale_cs_err", n_err - err0, 32'd0);
        frame(1, 8'h00, 24'h0F1E2D, rd);
        frame(1, 8'h80, 24'h000000, rd);
        chk("post_rst_rd", {8'd0, rd}, 32'h000F1E2D);
        chk("post_rst_done", n_done - done0, 32'd2);
        frame(1, 8'h83, 24'h000000, rd);
        chk("post_rst_stat", {8'd0, rd}, 32'h00000002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
